// File: rtl/moltiplicatore_sequenziale.sv
// Unsigned NxN shift-and-add multiplier: one shared ripple-carry adder iterated over N cycles,
// with a start/busy/done handshake and a 2N-bit registered product.

module sommatore_parallelo_con_riporto_seriale #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic carry_s;

  // Ripple carry chain, bit 0 first.
  always_comb begin
    carry_s = cin;
    s       = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      s[i]    = x[i] ^ y[i] ^ carry_s;
      carry_s = (x[i] & y[i]) | (carry_s & (x[i] ^ y[i]));
    end
    cout = carry_s;
  end

endmodule

module moltiplicatore_sequenziale #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [N-1:0]    m_r;
  logic [N-1:0]    acc_r;
  logic [N-1:0]    q_r;
  logic            c_r;
  logic [CW-1:0]   cnt_r;

  logic [N-1:0]    sum_s;
  logic            cout_s;
  logic [N-1:0]    acc_nxt_s;
  logic [N-1:0]    q_nxt_s;

  sommatore_parallelo_con_riporto_seriale #(.N(N)) u_adder (
    .x    (acc_r),
    .y    (m_r),
    .cin  (1'b0),
    .s    (sum_s),
    .cout (cout_s)
  );

  // One shift-and-add step: the carry (or C) becomes the new top bit of A.
  always_comb begin
    acc_nxt_s = acc_r;
    q_nxt_s   = q_r;
    if (q_r[0]) begin
      acc_nxt_s = {cout_s, sum_s[N-1:1]};
      q_nxt_s   = {sum_s[0], q_r[N-1:1]};
    end else begin
      acc_nxt_s = {c_r, acc_r[N-1:1]};
      q_nxt_s   = {acc_r[0], q_r[N-1:1]};
    end
  end

  // Control FSM with all datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      m_r     <= {N{1'b0}};
      acc_r   <= {N{1'b0}};
      q_r     <= {N{1'b0}};
      c_r     <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= {(2*N){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_r     <= a;
            q_r     <= b;
            acc_r   <= {N{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= CW'(N);
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          acc_r <= acc_nxt_s;
          q_r   <= q_nxt_s;
          c_r   <= 1'b0;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            p       <= {acc_nxt_s, q_nxt_s};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
